// File: rtl/time_uart_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : time_uart_tx_pkg
// Brief    : State encoding, ASCII constants and output byte-order table for
//            the timestamp UART transmitter.
// Revision : 1.0 - initial release
// ============================================================================
package time_uart_tx_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SNAP  = 3'd1,
        ST_CONV  = 3'd2,
        ST_LOAD  = 3'd3,
        ST_START = 3'd4,
        ST_DATA  = 3'd5,
        ST_STOP  = 3'd6,
        ST_FIN   = 3'd7
    } state_t;

    localparam logic [7:0] c_ascii_zero  = 8'h30;
    localparam logic [7:0] c_ascii_dash  = 8'h2D;
    localparam logic [7:0] c_ascii_colon = 8'h3A;
    localparam logic [7:0] c_ascii_space = 8'h20;
    localparam logic [7:0] c_ascii_cr    = 8'h0D;
    localparam logic [7:0] c_ascii_lf    = 8'h0A;

    // Entries with bit 7 set select digit buffer slot [3:0]; others are literal bytes.
    localparam logic [20:0][7:0] c_byte_order = {
        c_ascii_lf, c_ascii_cr, 8'h8D, 8'h8C, c_ascii_colon, 8'h8B, 8'h8A,
        c_ascii_colon, 8'h89, 8'h88, c_ascii_space, 8'h87, 8'h86, c_ascii_dash,
        8'h85, 8'h84, c_ascii_dash, 8'h83, 8'h82, 8'h81, 8'h80
    };

    function automatic logic [7:0] ascii_of(input logic [7:0] entry,
                                            input logic [13:0][3:0] digits);
        if (entry[7])
            return c_ascii_zero | {4'h0, digits[entry[3:0]]};
        return entry;
    endfunction

endpackage
`default_nettype wire

// File: rtl/time_uart_tx_if.sv
`default_nettype none
// ============================================================================
// Module   : time_uart_tx_if
// Brief    : Request, time-field and serial-line bundle of the transmitter.
// Revision : 1.0 - initial release
// ============================================================================
interface time_uart_tx_if;
    logic        send;
    logic [5:0]  second;
    logic [5:0]  minute;
    logic [4:0]  hour;
    logic [4:0]  day;
    logic [3:0]  month;
    logic [15:0] year;
    logic        tx;
    logic        busy;
    logic        done;

    modport master (output send, second, minute, hour, day, month, year,
                    input  tx, busy, done);
    modport slave  (input  send, second, minute, hour, day, month, year,
                    output tx, busy, done);
endinterface
`default_nettype wire

// File: rtl/time_uart_tx_bin2bcd.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd
// Brief    : Sequential double-dabble, 16-bit binary to 5 BCD digits,
//            17 cycles from start to the done pulse.
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd (
    input  wire logic        clk,
    input  wire logic        rst_n,
    input  wire logic        start,
    input  wire logic [15:0] bin,
    output logic      [19:0] bcd,
    output logic             done
);
    logic [35:0] r_shift;
    logic [4:0]  r_cnt;
    logic        r_active;
    logic        r_done;
    logic [35:0] w_adj;

    always_comb begin
        w_adj = r_shift;
        for (int d = 0; d < 5; d++) begin
            if (r_shift[16 + 4*d +: 4] >= 4'd5)
                w_adj[16 + 4*d +: 4] = r_shift[16 + 4*d +: 4] + 4'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shift  <= '0;
            r_cnt    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
        end else if (start && !r_active) begin
            r_shift  <= {20'd0, bin};
            r_cnt    <= 5'd16;
            r_active <= 1'b1;
            r_done   <= 1'b0;
        end else if (r_active) begin
            r_shift <= {w_adj[34:0], 1'b0};
            r_cnt   <= r_cnt - 5'd1;
            if (r_cnt == 5'd1) begin
                r_active <= 1'b0;
                r_done   <= 1'b1;
            end
        end else begin
            r_done <= 1'b0;
        end
    end

    assign bcd  = r_shift[35:16];
    assign done = r_done;
endmodule
`default_nettype wire

// File: rtl/time_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : time_uart_tx
// Brief    : Captures a date/time snapshot and sends it over UART as
//            "YYYY-MM-DD hh:mm:ss\r\n" (8N1, back-to-back bytes).
// Revision : 1.0 - initial release
// ============================================================================
module time_uart_tx
    import time_uart_tx_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 115_200
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    time_uart_tx_if.slave bus
);
    localparam int c_div   = CLK_FREQ / BAUD;
    localparam int c_cnt_w = (c_div > 1) ? $clog2(c_div) : 1;

    state_t              r_state, w_state_next;
    logic [15:0]         r_snap_year;
    logic [3:0]          r_snap_month;
    logic [4:0]          r_snap_day, r_snap_hour;
    logic [5:0]          r_snap_minute, r_snap_second;
    logic [2:0]          r_field;
    logic                r_cv_pend;
    logic [13:0][3:0]    r_digits;
    logic [4:0]          r_byte_idx;
    logic [2:0]          r_bit_idx;
    logic [7:0]          r_tx_byte;
    logic [c_cnt_w-1:0]  r_baud_cnt;

    logic                w_bit_end;
    logic [15:0]         w_cv_bin;
    logic                w_cv_start;
    logic [19:0]         w_bcd;
    logic                w_bcd_done;
    logic [3:0]          w_dig_hi;
    logic                w_tx, w_busy, w_done;
    logic                w_unused_tenk;

    bin2bcd u_bin2bcd (
        .clk   (clk),
        .rst_n (rst_n),
        .start (w_cv_start),
        .bin   (w_cv_bin),
        .bcd   (w_bcd),
        .done  (w_bcd_done)
    );

    // The ten-thousands digit of the year is intentionally dropped.
    assign w_unused_tenk = ^w_bcd[19:16];
    assign w_bit_end     = (r_baud_cnt == c_cnt_w'(c_div - 1));
    assign w_dig_hi      = {r_field, 1'b0} + 4'd2;

    always_comb begin
        case (r_field)
            3'd0:    w_cv_bin = r_snap_year;
            3'd1:    w_cv_bin = {12'd0, r_snap_month};
            3'd2:    w_cv_bin = {11'd0, r_snap_day};
            3'd3:    w_cv_bin = {11'd0, r_snap_hour};
            3'd4:    w_cv_bin = {10'd0, r_snap_minute};
            3'd5:    w_cv_bin = {10'd0, r_snap_second};
            default: w_cv_bin = 16'd0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_tx         = 1'b1;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        w_cv_start   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.send)
                    w_state_next = ST_SNAP;
            end
            ST_SNAP: w_state_next = ST_CONV;
            ST_CONV: begin
                w_cv_start = !r_cv_pend;
                if (w_bcd_done && r_field == 3'd5)
                    w_state_next = ST_LOAD;
            end
            ST_LOAD: w_state_next = ST_START;
            ST_START: begin
                w_tx = 1'b0;
                if (w_bit_end)
                    w_state_next = ST_DATA;
            end
            ST_DATA: begin
                w_tx = r_tx_byte[r_bit_idx];
                if (w_bit_end && r_bit_idx == 3'd7)
                    w_state_next = ST_STOP;
            end
            ST_STOP: begin
                if (w_bit_end)
                    w_state_next = (r_byte_idx == 5'd20) ? ST_FIN : ST_START;
            end
            ST_FIN: begin
                w_busy       = 1'b0;
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_snap_year   <= '0;
            r_snap_month  <= '0;
            r_snap_day    <= '0;
            r_snap_hour   <= '0;
            r_snap_minute <= '0;
            r_snap_second <= '0;
            r_field       <= '0;
            r_cv_pend     <= 1'b0;
            r_digits      <= '0;
            r_byte_idx    <= '0;
            r_bit_idx     <= '0;
            r_tx_byte     <= '0;
            r_baud_cnt    <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.send) begin
                        r_snap_year   <= bus.year;
                        r_snap_month  <= bus.month;
                        r_snap_day    <= bus.day;
                        r_snap_hour   <= bus.hour;
                        r_snap_minute <= bus.minute;
                        r_snap_second <= bus.second;
                        r_field       <= '0;
                        r_cv_pend     <= 1'b0;
                        r_byte_idx    <= '0;
                    end
                end
                ST_CONV: begin
                    if (!r_cv_pend) begin
                        r_cv_pend <= 1'b1;
                    end else if (w_bcd_done) begin
                        if (r_field == 3'd0) begin
                            r_digits[0] <= w_bcd[15:12];
                            r_digits[1] <= w_bcd[11:8];
                            r_digits[2] <= w_bcd[7:4];
                            r_digits[3] <= w_bcd[3:0];
                        end else begin
                            r_digits[w_dig_hi]        <= w_bcd[7:4];
                            r_digits[w_dig_hi + 4'd1] <= w_bcd[3:0];
                        end
                        r_cv_pend <= 1'b0;
                        r_field   <= r_field + 3'd1;
                    end
                end
                ST_LOAD: begin
                    r_tx_byte  <= ascii_of(c_byte_order[r_byte_idx], r_digits);
                    r_baud_cnt <= '0;
                end
                ST_START, ST_DATA, ST_STOP: begin
                    r_baud_cnt <= w_bit_end ? '0 : r_baud_cnt + 1'b1;
                    if (w_bit_end) begin
                        if (r_state == ST_START)
                            r_bit_idx <= '0;
                        else if (r_state == ST_DATA)
                            r_bit_idx <= r_bit_idx + 3'd1;
                        else if (r_byte_idx != 5'd20) begin
                            // Next byte is loaded on the stop edge so its start bit follows directly.
                            r_byte_idx <= r_byte_idx + 5'd1;
                            r_tx_byte  <= ascii_of(c_byte_order[r_byte_idx + 5'd1], r_digits);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.tx   = w_tx;
    assign bus.busy = w_busy;
    assign bus.done = w_done;
endmodule
`default_nettype wire

// File: tb/tb_time_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_time_uart_tx
// Brief    : Directed self-checking bench for time_uart_tx at DIV = 16.
// Revision : 1.0 - initial release
// ============================================================================
module tb_time_uart_tx;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    int         checks   = 0;
    int         errors   = 0;
    int         done_cnt = 0;
    logic [7:0] exp_str [21];

    time_uart_tx_if u_if ();

    time_uart_tx #(.CLK_FREQ(16), .BAUD(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (u_if.done === 1'b1) done_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load_exp(input logic [167:0] s);
        for (int i = 0; i < 21; i++) exp_str[i] = s[167 - 8*i -: 8];
    endtask

    task automatic set_time(input logic [15:0] y, input logic [3:0] mo, input logic [4:0] d,
                            input logic [4:0] h, input logic [5:0] mi, input logic [5:0] s);
        u_if.year = y; u_if.month = mo; u_if.day = d;
        u_if.hour = h; u_if.minute = mi; u_if.second = s;
    endtask

    // Called on a falling clock edge; returns on the falling edge after the stop bit.
    task automatic recv_byte(input int idx, input string tag);
        int         t;
        logic [7:0] d;
        logic       ok;
        logic       eb;
        t = 0;
        while (u_if.tx !== 1'b0 && t < 1000) begin @(negedge clk); t++; end
        if (t >= 1000) begin
            check($sformatf("%s start timeout byte %0d", tag, idx), 32'(t), 32'd0);
            return;
        end
        ok = 1'b1;
        d  = 8'h00;
        for (int b = 0; b < 10; b++) begin
            for (int c = 0; c < 16; c++) begin
                eb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : exp_str[idx][b-1];
                if (u_if.tx !== eb) ok = 1'b0;
                if (b >= 1 && b <= 8 && c == 8) d[b-1] = u_if.tx;
                @(negedge clk);
            end
        end
        check($sformatf("%s byte %0d frame/data", tag, idx), {23'd0, ok, d}, {23'd0, 1'b1, exp_str[idx]});
    endtask

    task automatic recv_string(input int n, input string tag);
        for (int i = 0; i < n; i++) recv_byte(i, tag);
    endtask

    task automatic pulse_send();
        u_if.send = 1'b1;
        @(negedge clk);
        u_if.send = 1'b0;
        check("busy after accept", {31'd0, u_if.busy}, 32'd1);
    endtask

    task automatic check_fin(input string tag);
        check({tag, " fin done/busy"}, {30'd0, u_if.done, u_if.busy}, 32'b10);
        @(negedge clk);
        check({tag, " post-fin done/busy"}, {30'd0, u_if.done, u_if.busy}, 32'b00);
    endtask

    initial begin
        u_if.send = 1'b0;
        set_time(16'd0, 4'd0, 5'd0, 5'd0, 6'd0, 6'd0);
        repeat (3) @(negedge clk);
        check("reset tx",   {31'd0, u_if.tx},   32'd1);
        check("reset busy", {31'd0, u_if.busy}, 32'd0);
        check("reset done", {31'd0, u_if.done}, 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 2024-03-07 09:05:59
        load_exp(168'h32303234_2D3033_2D3037_20_3039_3A3035_3A3539_0D0A);
        set_time(16'd2024, 4'd3, 5'd7, 5'd9, 6'd5, 6'd59);
        pulse_send();
        recv_string(21, "T1");
        check_fin("T1");
        repeat (2) @(negedge clk);
        check("T1 done count", 32'(done_cnt), 32'd1);

        // Year above 9999 keeps only the low four digits
        load_exp(168'h32333435_2D3030_2D3030_20_3030_3A3030_3A3030_0D0A);
        set_time(16'd12345, 4'd0, 5'd0, 5'd0, 6'd0, 6'd0);
        pulse_send();
        recv_string(21, "T2");
        check_fin("T2");
        repeat (2) @(negedge clk);
        check("T2 done count", 32'(done_cnt), 32'd2);

        // Inputs cleared right after accept; out-of-range second prints 63
        load_exp(168'h31393939_2D3132_2D3331_20_3233_3A3539_3A3633_0D0A);
        set_time(16'd1999, 4'd12, 5'd31, 5'd23, 6'd59, 6'd63);
        pulse_send();
        set_time(16'd0, 4'd0, 5'd0, 5'd0, 6'd0, 6'd0);
        recv_string(21, "T3");
        check_fin("T3");
        repeat (2) @(negedge clk);
        check("T3 done count", 32'(done_cnt), 32'd3);

        // send held high: one timestamp per accept, re-accept after the done cycle
        load_exp(168'h32303234_2D3033_2D3037_20_3039_3A3035_3A3539_0D0A);
        set_time(16'd2024, 4'd3, 5'd7, 5'd9, 6'd5, 6'd59);
        u_if.send = 1'b1;
        @(negedge clk);
        check("T4 busy after accept", {31'd0, u_if.busy}, 32'd1);
        recv_string(21, "T4a");
        check("T4a fin done/busy", {30'd0, u_if.done, u_if.busy}, 32'b10);
        @(negedge clk);
        check("T4 idle gap busy", {31'd0, u_if.busy}, 32'd0);
        @(negedge clk);
        check("T4 re-accept busy", {31'd0, u_if.busy}, 32'd1);
        recv_string(21, "T4b");
        u_if.send = 1'b0;
        check_fin("T4b");
        repeat (2) @(negedge clk);
        check("T4 done count", 32'(done_cnt), 32'd5);

        // Reset during DATA of byte 5
        pulse_send();
        recv_string(4, "T5");
        repeat (16 + 3*16 + 5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("T5 reset tx",   {31'd0, u_if.tx},   32'd1);
        check("T5 reset busy", {31'd0, u_if.busy}, 32'd0);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        check("T5 idle after reset busy", {31'd0, u_if.busy}, 32'd0);
        check("T5 idle after reset tx",   {31'd0, u_if.tx},   32'd1);
        check("T5 no done on abort", 32'(done_cnt), 32'd5);
        pulse_send();
        recv_string(21, "T5r");
        check_fin("T5r");
        repeat (2) @(negedge clk);
        check("T5 done count", 32'(done_cnt), 32'd6);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/time_uart_tx.md
TIME_UART_TX -- requirements
Module: time_uart_tx

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, input clock frequency in Hz.
REQ-002 Parameter BAUD, default 115_200, serial bit rate; DIV = CLK_FREQ/BAUD cycles per bit, integer division, DIV >= 2.
REQ-003 clk  input  1  single clock; all state on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 send  input  1  request to transmit one timestamp; level sampled each cycle.
REQ-006 second  input  6  binary seconds, 0..59.
REQ-007 minute  input  6  binary minutes, 0..59.
REQ-008 hour  input  5  binary hours, 0..23.
REQ-009 day  input  5  binary day, 1..31.
REQ-010 month  input  4  binary month, 1..12.
REQ-011 year  input  16  binary year, 0..65535.
REQ-012 tx  output  1  UART line; idle high.
REQ-013 busy  output  1  high from accept of send until done.
REQ-014 done  output  1  one-cycle pulse after last stop bit.

Function
REQ-015 FSM states: IDLE, SNAP, CONV, LOAD, START, DATA, STOP, FIN.
REQ-016 In IDLE with send=1: capture all six time inputs into snapshot registers, go to SNAP; busy=1 from the next cycle.
REQ-017 send while busy=1 is ignored; no queuing.
REQ-018 Time input changes after capture do not affect the output; only the snapshot is used.
REQ-019 CONV: fields converted to BCD one at a time through bin2bcd in order year, month, day, hour, minute, second; results held in a 14-digit buffer.
REQ-020 Year printed as four digits = year mod 10000; the ten-thousands digit is discarded.
REQ-021 Every other field printed as exactly two digits with leading zero; out-of-range values print their low two decimal digits.
REQ-022 Output string, 21 bytes, fixed order: Y Y Y Y '-' M M '-' D D ' ' h h ':' m m ':' s s 0x0D 0x0A; digits are ASCII 0x30+digit.
REQ-023 Each byte framed as 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit held exactly DIV cycles.
REQ-024 Bytes are sent back-to-back: the next start bit begins in the cycle after the previous stop bit ends; no idle gap inside a timestamp.
REQ-025 After the stop bit of byte 21: FIN asserts done=1 for one cycle, busy=0 in that same cycle, return to IDLE.
REQ-026 send=1 in the done cycle is ignored; it is accepted from the following cycle.
REQ-027 tx=1 in every state except START and DATA.

Reset
REQ-028 rst_n=0 forces immediately: tx=1, busy=0, done=0, state IDLE, baud counter, byte index, bit index and snapshot cleared.
REQ-029 Reset mid-frame aborts the transfer with no completion pulse; after release the block waits for a new send.

Structure
REQ-030 Shared package holds the state encoding, ASCII constants (0x30, '-', ':', ' ', CR, LF) and the 21-entry byte-order table.
REQ-031 One sub-module, bin2bcd: sequential double-dabble, 16-bit input, 5 BCD digits out, start/done handshake, 17 cycles per conversion.

Verification (CLK_FREQ=16, BAUD=1, DIV=16)
REQ-032 year=2024, month=3, day=7, hour=9, minute=5, second=59, send pulse -> tx carries bytes 32 30 32 34 2D 30 33 2D 30 37 20 30 39 3A 30 35 3A 35 39 0D 0A; each bit lasts 16 cycles; single done pulse.
REQ-033 year=12345, other fields 0 -> first four bytes 32 33 34 35; month field bytes 30 30.
REQ-034 Inputs changed to all-zero one cycle after send -> transmitted string still matches the values captured at send.
REQ-035 send held high for the whole transfer -> exactly one timestamp per accept, next accept only after the done cycle; done pulses once per timestamp.
REQ-036 rst_n low during byte 5 DATA -> tx=1 and busy=0 at once, no done pulse; a new send afterwards produces a complete, correct 21-byte string.
